mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 3, consecutive IF denials before the starvation guard forces an IF grant.
REQ-004 The block SHALL use one clock and synchronous, active-low reset; ports as listed below.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 if_req  in  1  instruction-fetch read request.
REQ-008 if_addr  in  ADDR_W  fetch word address.
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid / if_rdata  out  1 / DATA_W  fetch read response.
REQ-011 dm_req, dm_we  in  1, 1  data-port request; we=1 write, we=0 read.
REQ-012 dm_addr / dm_wdata  in  ADDR_W / DATA_W  data address and write data.
REQ-013 dm_gnt  out  1  data request accepted this cycle.
REQ-014 dm_rvalid / dm_rdata  out  1 / DATA_W  data read response.
REQ-015 mem_addr, mem_we, mem_re, mem_wdata  out  ADDR_W, 1, 1, DATA_W  drive to the single-port memory.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re.
REQ-017 stall_if  out  1  high when if_req=1 and if_gnt=0.

Function
REQ-018 Grants SHALL be combinational from the current requests and state; at most one of if_gnt, dm_gnt is high per cycle.
REQ-019 Default priority SHALL go to the data port (older instruction): dm_req=1 means dm_gnt=1 unless the guard forces IF.
REQ-020 The granted requester's address, we, and wdata SHALL drive mem_* in the same cycle. mem_re=gnt&~we, mem_we=dm_gnt&dm_we. With no grant, mem_re=mem_we=0.
REQ-021 The FSM states SHALL be IDLE, RESP_IF, RESP_DM, recording the owner of the read issued in the previous cycle.
REQ-022 Next state: RESP_IF if the fetch read is granted, RESP_DM if the data read is granted, otherwise IDLE (including granted writes).
REQ-023 In RESP_IF, if_rvalid=1 and if_rdata=mem_rdata. In RESP_DM, dm_rvalid=1 and dm_rdata=mem_rdata. Read latency is exactly 1 cycle.
REQ-024 Back-to-back reads SHALL be supported: a new grant is allowed in every state, and the response and the new issue overlap.
REQ-025 Response data SHALL be 0 when the corresponding rvalid=0.
REQ-026 Writes produce no response; dm_gnt is the only acknowledgement.
REQ-027 Starvation counter wait_cnt, width clog2(MAX_WAIT+1):
- increments, saturating at MAX_WAIT, on each cycle with stall_if=1;
- clears on if_gnt or when if_req=0.
REQ-028 Simultaneous requests with no forced grant: dm wins and stall_if=1.

Reset
REQ-029 Reset SHALL set state=IDLE, wait_cnt=0, all rvalid=0, and all rdata=0. Grants and mem_* are 0 while rst=0.
REQ-030 Reset asserted with a read outstanding SHALL drop that read; no rvalid appears after reset is released.

Configuration
REQ-031 Macro MEM_ARB_STARVE_GUARD_EN enables the starvation guard.
- Defined: when wait_cnt==MAX_WAIT and if_req=1, the IF port is granted and dm_gnt=0 for that cycle.
- Undefined: fixed data priority; wait_cnt is not implemented.

Structure
REQ-032 A shared package mips_pkg SHALL hold:
- the state enum (IDLE, RESP_IF, RESP_DM);
- MEM_ADDR_W=6 and MIPS_DATA_W=32 constants, used as parameter defaults.
REQ-033 Sub-module arb_starve_cnt SHALL hold the saturating counter, instantiated only under MEM_ARB_STARVE_GUARD_EN; the FSM and muxing stay in the top.

Verification
REQ-034 if_req=1, if_addr=5, dm_req=0, mem[5]=0xDEADBEEF -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
REQ-035 if_req=1 and dm_req=1, dm_we=1, dm_addr=3, dm_wdata=0x12345678 -> dm_gnt=1, mem_we=1, stall_if=1, if_gnt=0; no rvalid next cycle.
REQ-036 Reads alternating every cycle (IF addr 1, then DM addr 2, then IF addr 3) -> rvalid on the matching port at each following cycle, data=mem[1], mem[2], mem[3].
REQ-037 Guard enabled, MAX_WAIT=3, if_req and dm_req held high -> dm granted 3 cycles, IF granted on the 4th, then dm again; guard disabled -> IF never granted.
REQ-038 DM read granted, rst=0 on the next edge -> dm_rvalid=0 in all cycles after reset; state=IDLE and wait_cnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and width defaults for the memory arbiter slice.
// Holds the response-owner state encoding used by mem_arbiter.
package mips_pkg;

  localparam int unsigned MEM_ADDR_W  = 6;
  localparam int unsigned MIPS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } arb_state_e;

  // Counter width for a saturating count up to max_wait, never narrower than one bit.
  function automatic int unsigned starve_cnt_w(input int unsigned max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive instruction-fetch denials.
// Used by mem_arbiter only when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_cnt import mips_pkg::*; #(
  parameter int unsigned MaxWait = 3,
  parameter int unsigned CntW    = starve_cnt_w(MaxWait)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o,
  output logic            sat_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (stall_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after MAX_WAIT denials.
module mem_arbiter import mips_pkg::*; #(
  parameter int unsigned ADDR_W   = MEM_ADDR_W,
  parameter int unsigned DATA_W   = MIPS_DATA_W,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  localparam logic [1:0] StIdle   = IDLE;
  localparam logic [1:0] StRespIf = RESP_IF;
  localparam logic [1:0] StRespDm = RESP_DM;

  logic [1:0] state_q, state_d;
  logic       force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = starve_cnt_w(MAX_WAIT);

  logic [CntW-1:0] wait_cnt;
  logic            wait_sat;

  arb_starve_cnt #(
    .MaxWait (MAX_WAIT),
    .CntW    (CntW)
  ) u_starve_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .stall_i (stall_if),
    .clr_i   (if_gnt | ~if_req),
    .cnt_o   (wait_cnt),
    .sat_o   (wait_sat)
  );

  assign force_if = if_req & wait_sat;
`else
  assign force_if = 1'b0;
`endif

  // Data port is the older instruction, so it wins unless the guard forces a fetch.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst) begin
      if (force_if) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign stall_if = if_req & ~if_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_we    = dm_we;
      mem_re    = ~dm_we;
    end else if (if_gnt) begin
      mem_addr = if_addr;
      mem_re   = 1'b1;
    end
  end

  // State records who owns the read issued this cycle; writes leave nothing outstanding.
  always_comb begin
    state_d = StIdle;
    if (if_gnt) begin
      state_d = StRespIf;
    end else if (dm_gnt && !dm_we) begin
      state_d = StRespDm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign if_rvalid = (state_q == StRespIf);
  assign dm_rvalid = (state_q == StRespDm);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural one-cycle memory.
module tb_mem_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re, stall_if;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if)
  );

  // Single-port memory: read data appears the cycle after mem_re; reset loads known contents.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hA000_0000 + i;
      mem[5]    <= 32'hDEAD_BEEF;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic [4:0]    e_ctl;  // {if_gnt, dm_gnt, mem_re, mem_we, stall_if}
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_wd;
    logic          e_iv;
    logic [DW-1:0] e_id;
    logic          e_dv;
    logic [DW-1:0] e_dd;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
  endtask

  logic prev_ig, prev_dg, exp_ig;

  initial begin
    // Outputs within a cycle reflect the read issued in the previous row.
    vecs[0]  = '{1, 5, 0, 0, 0, 0,            5'b10100, 5, 0,            0, 0,            0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0,            5'b00000, 0, 0,            1, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{1, 7, 1, 1, 3, 32'h12345678, 5'b01011, 3, 32'h12345678, 0, 0,            0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,            5'b00000, 0, 0,            0, 0,            0, 0};
    vecs[4]  = '{0, 0, 1, 0, 3, 0,            5'b01100, 3, 0,            0, 0,            0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,            5'b00000, 0, 0,            0, 0,            1, 32'h12345678};
    vecs[6]  = '{1, 1, 0, 0, 0, 0,            5'b10100, 1, 0,            0, 0,            0, 0};
    vecs[7]  = '{0, 0, 1, 0, 2, 0,            5'b01100, 2, 0,            1, 32'hA0000001, 0, 0};
    vecs[8]  = '{1, 3, 0, 0, 0, 0,            5'b10100, 3, 0,            0, 0,            1, 32'hA0000002};
    vecs[9]  = '{0, 0, 1, 1, 9, 32'hCAFEF00D, 5'b01010, 9, 32'hCAFEF00D, 1, 32'h12345678, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 9, 0,            5'b01100, 9, 0,            0, 0,            0, 0};
    vecs[11] = '{1, 2, 0, 0, 0, 0,            5'b10100, 2, 0,            0, 0,            1, 32'hCAFEF00D};
    vecs[12] = '{0, 0, 0, 0, 0, 0,            5'b00000, 0, 0,            1, 32'hA0000002, 0, 0};

    // Reset with both ports requesting: nothing may be granted or driven.
    rst = 1'b0;
    drive(1, 5, 1, 1, 3, 32'h1111_1111);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      check("reset_ctl", {if_gnt, dm_gnt, mem_re, mem_we}, 4'b0000);
      check("reset_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
      check("reset_rdata", {if_rdata, dm_rdata}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      drive(vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].dw, vecs[v].da, vecs[v].dd);
      #2;
      check($sformatf("v%0d_ctl", v), {if_gnt, dm_gnt, mem_re, mem_we, stall_if}, vecs[v].e_ctl);
      check($sformatf("v%0d_addr", v), mem_addr, vecs[v].e_ma);
      check($sformatf("v%0d_wdata", v), mem_wdata, vecs[v].e_wd);
      check($sformatf("v%0d_if_rsp", v), {if_rvalid, if_rdata}, {vecs[v].e_iv, vecs[v].e_id});
      check($sformatf("v%0d_dm_rsp", v), {dm_rvalid, dm_rdata}, {vecs[v].e_dv, vecs[v].e_dd});
    end

    // Both ports held: guard grants IF every 4th cycle, otherwise IF never wins.
    prev_ig = 0; prev_dg = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k < 8) drive(1, 4, 1, 0, 6, 0);
      else drive(0, 0, 0, 0, 0, 0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_ig = (k < 8) && ((k % 4) == 3);
`else
      exp_ig = 1'b0;
`endif
      #2;
      if (k < 8) begin
        check($sformatf("starve%0d_gnt", k), {if_gnt, dm_gnt, stall_if}, {exp_ig, ~exp_ig, ~exp_ig});
      end
      check($sformatf("starve%0d_if_rsp", k), {if_rvalid, if_rdata},
            {prev_ig, prev_ig ? 32'hA0000004 : 32'h0});
      check($sformatf("starve%0d_dm_rsp", k), {dm_rvalid, dm_rdata},
            {prev_dg, prev_dg ? 32'hA0000006 : 32'h0});
      prev_ig = exp_ig;
      prev_dg = (k < 8) && !exp_ig;
    end

    // Build up two IF denials, then reset on the edge that would launch a DM read.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, 4, 1, 0, 2, 0);
    end
    @(negedge clk);
    drive(1, 4, 1, 0, 2, 0);
    #2;
    check("rst_drop_gnt", dm_gnt, 1'b1);
    #1;
    rst = 1'b0;
    dm_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #2;
      check($sformatf("rst_drop_in%0d", c), {dm_rvalid, dm_rdata, if_rvalid}, 34'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1, 4, 1, 0, 2, 0);
    #2;
    check("rst_drop_after", {dm_rvalid, if_rvalid}, 2'b00);
    // A cleared counter means three more DM wins before the guard fires.
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_ig = (k == 3);
`else
      exp_ig = 1'b0;
`endif
      if (k > 0) begin
        @(negedge clk); #2;
      end
      check($sformatf("post_rst%0d_gnt", k), {if_gnt, dm_gnt}, {exp_ig, ~exp_ig});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
